// File: rtl/fifo_256_60bit_rd_stream.sv
// Read-side drain for the 256x60 FIFO: pops the FIFO and absorbs its 1-cycle read latency.
// Presents a valid/ready stream through a 2-entry buffer; pops stop once buffer plus in-flight words reach 2.
module fifo_256_60bit_rd_stream #(
  parameter int DW = 60,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          fifo_empty,
  input  logic [DW-1:0] fifo_dout,
  output logic          fifo_re,
  output logic          fifo_clr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [CW-1:0] word_count
);

  logic [1:0]    r_occ;
  logic          r_inflight;
  logic [DW-1:0] r_buf0;
  logic [DW-1:0] r_buf1;
  logic [CW-1:0] r_word_count;
  logic          w_pop;
  logic [2:0]    w_level;

  assign out_valid  = (r_occ != 2'd0);
  assign out_data   = r_buf0;
  assign word_count = r_word_count;
  assign fifo_clr   = clr;
  assign w_pop      = out_valid & out_ready;

  // Slots committed after this edge; a pop this cycle frees one in time for a new read.
  assign w_level = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign fifo_re = ~rst & ~clr & ~fifo_empty & (w_level < 3'd2);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_occ        <= 2'd0;
      r_inflight   <= 1'b0;
      r_word_count <= '0;
      r_buf0       <= '0;
      r_buf1       <= '0;
    end else begin
      r_inflight <= fifo_re;
      if (w_pop) begin
        r_word_count <= r_word_count + {{(CW-1){1'b0}}, 1'b1};
      end
      case ({r_inflight, w_pop})
        2'b10: begin
          if (r_occ == 2'd0) begin
            r_buf0 <= fifo_dout;
          end else begin
            r_buf1 <= fifo_dout;
          end
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_buf0 <= r_buf1;
          r_occ  <= r_occ - 2'd1;
        end
        2'b11: begin
          if (r_occ == 2'd1) begin
            r_buf0 <= fifo_dout;
          end else begin
            r_buf0 <= r_buf1;
            r_buf1 <= fifo_dout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_256_60bit_rd_stream.sv
// Bench for fifo_256_60bit_rd_stream: queue-based FIFO and in-order stream scoreboard.
module tb_fifo_256_60bit_rd_stream;
  localparam int DW = 60;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr;
  logic          fifo_empty;
  logic [DW-1:0] fifo_dout;
  logic          fifo_re;
  logic          fifo_clr;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] word_count;

  fifo_256_60bit_rd_stream #(.DW(DW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_re(fifo_re),
    .fifo_clr(fifo_clr), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .word_count(word_count)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  logic [CW-1:0] mdl_wc;
  int            n_chk = 0;
  int            n_err = 0;
  logic          obs_re, obs_valid;
  logic [DW-1:0] obs_data;
  logic          prev_stall;
  logic [DW-1:0] prev_data;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // One clock cycle, entered and left just after a falling edge with inputs already set.
  task automatic step();
    logic re;
    #1;
    obs_re    = fifo_re;
    obs_valid = out_valid;
    obs_data  = out_data;
    check_eq("fifo_clr", fifo_clr, clr);
    if (fifo_re) check_eq("re_while_empty", fifo_empty, 1'b0);
    if (prev_stall) begin
      check_eq("hold_valid", out_valid, 1'b1);
      check_eq("hold_data", out_data, prev_data);
    end
    if (!rst && !clr && out_valid && out_ready) begin
      if (exp_q.size() == 0) check_eq("extra_word", out_valid, 1'b0);
      else check_eq("data", out_data, exp_q.pop_front());
      mdl_wc = mdl_wc + 1'b1;
    end
    prev_stall = !rst && !clr && out_valid && !out_ready;
    prev_data  = out_data;
    re = fifo_re;
    @(posedge clk);
    #1;
    if (rst || clr) begin
      mdl_wc = '0;
      fifo_q.delete();
      exp_q.delete();
    end
    if (re && fifo_q.size() > 0) fifo_dout = fifo_q.pop_front();
    fifo_empty = (fifo_q.size() == 0);
    check_eq("word_count", word_count, mdl_wc);
    @(negedge clk);
  endtask

  task automatic drain(input string tag, input int max_cycles);
    int n = 0;
    while (exp_q.size() > 0 && n < max_cycles) begin
      step();
      n++;
    end
    check_eq(tag, exp_q.size(), 0);
  endtask

  initial begin
    logic [CW-1:0] wc0;
    int            pushed;
    rst = 1'b1; clr = 1'b0; fifo_empty = 1'b1; fifo_dout = '0; out_ready = 1'b0;
    mdl_wc = '0; prev_stall = 1'b0; prev_data = '0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("rst_re", obs_re, 1'b0);
    end
    rst = 1'b0;
    step();
    check_eq("rst_valid", obs_valid, 1'b0);
    check_eq("rst_data", obs_data, 0);

    // single word: pop at t0, visible at t0+2 for one cycle
    out_ready = 1'b1;
    push(60'hABC);
    for (int c = 0; c < 5; c++) begin
      step();
      check_eq("single_re", obs_re, (c == 0));
      check_eq("single_valid", obs_valid, (c == 2));
    end
    check_eq("single_wc", word_count, 1);

    // streaming, no bubbles
    for (int i = 1; i <= 8; i++) push(DW'(i));
    for (int c = 0; c < 12; c++) begin
      step();
      check_eq("stream_re", obs_re, (c < 8));
      check_eq("stream_valid", obs_valid, (c >= 2 && c < 10));
    end
    check_eq("stream_wc", word_count, 9);

    // backpressure: at most two words leave the FIFO during the stall
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(DW'(i));
    for (int c = 0; c < 5; c++) begin
      step();
      check_eq("bp_re", obs_re, (c < 2));
      if (c >= 2) begin
        check_eq("bp_valid", obs_valid, 1'b1);
        check_eq("bp_data", obs_data, 1);
      end
    end
    check_eq("bp_fifo_left", fifo_q.size(), 6);
    out_ready = 1'b1;
    drain("bp_drain", 40);
    step();
    check_eq("bp_wc", word_count, 17);

    // random backpressure with trickling writes
    wc0 = word_count;
    pushed = 0;
    for (int c = 0; c < 4000 && !(pushed == 256 && exp_q.size() == 0); c++) begin
      if (pushed < 256 && $urandom_range(0, 1) == 1) begin
        push(DW'(60'h100 + pushed));
        pushed++;
      end
      out_ready = ($urandom_range(0, 1) == 1);
      step();
    end
    check_eq("rand_pushed", pushed, 256);
    check_eq("rand_left", exp_q.size(), 0);
    out_ready = 1'b1;
    step();
    step();
    check_eq("rand_empty", fifo_empty, 1'b1);
    check_eq("rand_idle_valid", obs_valid, 1'b0);
    check_eq("rand_wc", word_count, wc0 + 16'd256);

    // flush with words buffered and in flight
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(DW'(60'hF00 + i));
    step();
    step();
    clr = 1'b1;
    step();
    check_eq("flush_re", obs_re, 1'b0);
    check_eq("flush_wc", word_count, 0);
    clr = 1'b0;
    step();
    check_eq("flush_valid", obs_valid, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) push(DW'(60'h200 + i));
    drain("flush_drain", 40);
    for (int i = 0; i < 3; i++) step();
    check_eq("flush_after_wc", word_count, 3);

    // reset mid-stream
    for (int i = 0; i < 6; i++) push(DW'(60'h300 + i));
    step();
    step();
    rst = 1'b1;
    step();
    check_eq("mid_rst_re", obs_re, 1'b0);
    rst = 1'b0;
    step();
    check_eq("mid_rst_valid", obs_valid, 1'b0);
    check_eq("mid_rst_data", obs_data, 0);
    check_eq("mid_rst_re_after", obs_re, 1'b0);
    check_eq("mid_rst_wc", word_count, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
